// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH   = 256;
    localparam int DEFAULT_LATENCY = 3;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array with synchronous write and registered read
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH];

    // Read-before-write: a same-edge read returns the old word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
        rdata_o <= mem[idx_i];
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with req/ack handshake
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..15");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cap_we;
    logic [31:0]      cap_addr;
    logic [31:0]      cap_wdata;
    logic [AW-1:0]    hold_idx;
    logic             rd_valid;

    logic             commit;
    logic             c_we;
    logic [31:0]      c_addr;
    logic [31:0]      c_wdata;
    logic             c_err;
    logic [AW-1:0]    c_idx;
    logic             arr_we;
    logic [AW-1:0]    arr_idx;
    logic [31:0]      arr_rdata;

    // With LATENCY = 1 the access commits on the accept edge, straight from the inputs.
    always_comb begin
        if (LATENCY == 1) begin
            commit  = !rst_i && (state == IDLE) && req_i;
            c_we    = we_i;
            c_addr  = addr_i;
            c_wdata = wdata_i;
        end else begin
            commit  = !rst_i && (state == WAIT) && (cnt == '0);
            c_we    = cap_we;
            c_addr  = cap_addr;
            c_wdata = cap_wdata;
        end
        c_err = (c_addr[1:0] != 2'b00) || ({2'b00, c_addr[31:2]} >= 32'(DEPTH));
        c_idx = c_addr[AW+1:2];
    end

    // Between commits the array keeps re-reading the last committed word so rdata_o holds.
    assign arr_we  = commit && c_we && !c_err;
    assign arr_idx = commit ? c_idx : hold_idx;
    assign rdata_o = rd_valid ? arr_rdata : 32'h0;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .idx_i   (arr_idx),
        .wdata_i (c_wdata),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            hold_idx  <= '0;
            rd_valid  <= 1'b0;
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            if (commit) begin
                hold_idx <= c_idx;
                rd_valid <= !c_we && !c_err;
                err_o    <= c_err;
                ack_o    <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req_i) begin
                        cap_we    <= we_i;
                        cap_addr  <= addr_i;
                        cap_wdata <= wdata_i;
                        busy_o    <= 1'b1;
                        if (LATENCY == 1) begin
                            state <= DONE;
                        end else begin
                            cnt   <= CNT_W'(LATENCY - 2);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (LATENCY 3 and 1 builds)
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        sel = 1'b0;

    logic        ack0, err0, busy0, ack1, err1, busy1;
    logic [31:0] rdata0, rdata1;
    logic        s_ack, s_err, s_busy;
    logic [31:0] s_rdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [DEPTH];

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        bit          er;
    } vec_t;

    vec_t vt [8];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ack_o(ack0), .rdata_o(rdata0), .err_o(err0), .busy_o(busy0)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ack_o(ack1), .rdata_o(rdata1), .err_o(err1), .busy_o(busy1)
    );

    assign s_ack   = sel ? ack1 : ack0;
    assign s_err   = sel ? err1 : err0;
    assign s_busy  = sel ? busy1 : busy0;
    assign s_rdata = sel ? rdata1 : rdata0;

    function automatic logic [31:0] init_val(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    function automatic void model_ref(input bit w, input logic [31:0] a, input logic [31:0] d,
                                      output logic [31:0] rd, output bit er);
        er = (a % 4 != 0) || (a / 4 >= DEPTH);
        rd = 32'h0;
        if (!er) begin
            if (w) model[a / 4] = d;
            else   rd = model[a / 4];
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input string name, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input bit exp_er, input int exp_lat,
                          input bit glitch);
        int n;
        bit seen;
        seen = 0;
        we = w; addr = a; wdata = d;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        for (n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (glitch && n == 1) begin
                addr  = 32'h20;
                wdata = 32'h1;
            end
            if (s_ack) begin
                seen = 1;
                break;
            end
            check({name, " busy_wait"}, 32'(s_busy), 32'd1);
        end
        req0 = 1'b0; req1 = 1'b0;
        check({name, " ack_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, " latency"}, n, exp_lat);
            check({name, " rdata"}, s_rdata, exp_rd);
            check({name, " err"}, 32'(s_err), 32'(exp_er));
            check({name, " busy_ack"}, 32'(s_busy), 32'd1);
        end
        @(posedge clk); #1;
        check({name, " ack_single"}, 32'(s_ack), 32'd0);
        check({name, " busy_idle"}, 32'(s_busy), 32'd0);
    endtask

    task automatic back_to_back(input int gap, input logic [31:0] a1, input logic [31:0] a2,
                                input logic [31:0] e1, input logic [31:0] e2);
        int t1, t2, nack;
        t1 = -1; t2 = -1; nack = 0;
        we = 1'b0; addr = a1;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        for (int c = 1; c <= 3 * gap + 4; c++) begin
            @(posedge clk); #1;
            if (s_ack) begin
                nack++;
                if (nack == 1) begin
                    t1 = c;
                    check("b2b rdata1", s_rdata, e1);
                    addr = a2;
                end else if (nack == 2) begin
                    t2 = c;
                    check("b2b rdata2", s_rdata, e2);
                    req0 = 1'b0; req1 = 1'b0;
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("b2b ack_count", nack, 2);
        check("b2b first_latency", t1, gap - 1);
        check("b2b spacing", t2 - t1, gap);
    endtask

    initial begin
        logic [31:0] erd;
        bit          eer;
        logic [31:0] ra, rd;
        bit          rw;

        vt[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vt[1] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vt[2] = '{1'b1, 32'h13,  32'h0BADF00D, 32'h0,        1'b1};
        vt[3] = '{1'b0, 32'h400, 32'h0,        32'h0,        1'b1};
        vt[4] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vt[5] = '{1'b0, 32'h3FC, 32'h0,        32'h100000FF, 1'b0};
        vt[6] = '{1'b1, 32'h3FD, 32'h11111111, 32'h0,        1'b1};
        vt[7] = '{1'b0, 32'h0,   32'h0,        32'h10000000, 1'b0};

        // Reset state of both builds.
        @(negedge clk); @(negedge clk);
        check("rst ack",   32'(ack0),  32'd0);
        check("rst err",   32'(err0),  32'd0);
        check("rst busy",  32'(busy0), 32'd0);
        check("rst rdata", rdata0,     32'd0);
        check("rst1 ack",  32'(ack1),  32'd0);
        check("rst1 err",  32'(err1),  32'd0);
        check("rst1 busy", 32'(busy1), 32'd0);
        check("rst1 rdata", rdata1,    32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fill every word with a known pattern.
        for (int i = 0; i < DEPTH; i++) begin
            model_ref(1'b1, 32'(i * 4), init_val(i), erd, eer);
            access("init", 1'b1, 32'(i * 4), init_val(i), erd, eer, 3, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            model_ref(vt[i].we, vt[i].addr, vt[i].wdata, erd, eer);
            access($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].wdata, vt[i].rd, vt[i].er, 3, 1'b0);
        end

        // Inputs changed during WAIT must not affect the captured store.
        model_ref(1'b1, 32'h10, 32'hCAFE0000, erd, eer);
        access("stable store", 1'b1, 32'h10, 32'hCAFE0000, 32'h0, 1'b0, 3, 1'b1);
        access("stable ld10", 1'b0, 32'h10, 32'h0, 32'hCAFE0000, 1'b0, 3, 1'b0);
        access("stable ld20", 1'b0, 32'h20, 32'h0, init_val(8), 1'b0, 3, 1'b0);

        back_to_back(4, 32'h10, 32'h3FC, 32'hCAFE0000, init_val(255));

        // Reset during WAIT aborts the store and clears outputs at once.
        access("pre-abort ld", 1'b0, 32'h10, 32'h0, 32'hCAFE0000, 1'b0, 3, 1'b0);
        check("rdata hold", rdata0, 32'hCAFE0000);
        we = 1'b1; addr = 32'h8; wdata = 32'h55AA55AA; req0 = 1'b1;
        @(posedge clk); #1;
        check("abort busy_before", 32'(busy0), 32'd1);
        rst = 1'b1;
        #1;
        check("abort ack",   32'(ack0),  32'd0);
        check("abort busy",  32'(busy0), 32'd0);
        check("abort err",   32'(err0),  32'd0);
        check("abort rdata", rdata0,     32'd0);
        req0 = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("abort no_ack", 32'(ack0), 32'd0);
        end
        access("abort ld8", 1'b0, 32'h8, 32'h0, init_val(2), 1'b0, 3, 1'b0);

        // Randomised traffic against the model.
        for (int k = 0; k < 300; k++) begin
            rw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       ra = $urandom;
                1:       ra = ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
                default: ra = $urandom_range(0, 255) << 2;
            endcase
            rd = $urandom;
            model_ref(rw, ra, rd, erd, eer);
            access("rand", rw, ra, rd, erd, eer, 3, 1'b0);
        end

        // LATENCY = 1 build.
        sel = 1'b1;
        access("l1 store", 1'b1, 32'h4, 32'h12345678, 32'h0, 1'b0, 1, 1'b0);
        access("l1 load", 1'b0, 32'h4, 32'h0, 32'h12345678, 1'b0, 1, 1'b0);
        access("l1 oor", 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        access("l1 misal", 1'b1, 32'h7, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b0);
        access("l1 reload", 1'b0, 32'h4, 32'h0, 32'h12345678, 1'b0, 1, 1'b0);
        back_to_back(2, 32'h4, 32'h4, 32'h12345678, 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
